// File: rtl/mc_control_if.sv
// Control bus between the multicycle MIPS main controller and its datapath.
// The master side (controller) drives all strobes and selects; the slave side supplies opcode and memory ready.
interface mc_control_if;
    logic [5:0] op;
    logic       mem_ready;
    logic       pcwrite;
    logic       pcwritecond;
    logic       iord;
    logic       memread;
    logic       memwrite;
    logic       irwrite;
    logic       memtoreg;
    logic       regdst;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic       aluop1;
    logic       aluop0;
    logic [1:0] pcsource;
    logic       illegal;
    logic [3:0] state;

    modport master (
        input  op, mem_ready,
        output pcwrite, pcwritecond, iord, memread, memwrite, irwrite, memtoreg,
               regdst, regwrite, alusrca, alusrcb, aluop1, aluop0, pcsource,
               illegal, state
    );

    modport slave (
        output op, mem_ready,
        input  pcwrite, pcwritecond, iord, memread, memwrite, irwrite, memtoreg,
               regdst, regwrite, alusrca, alusrcb, aluop1, aluop0, pcsource,
               illegal, state
    );
endinterface

// File: rtl/mc_control.sv
// Multicycle MIPS main control FSM: Moore outputs per state, FETCH strobes gated by mem_ready.
// Memory states hold while mem_ready is low; undefined opcodes return to FETCH with a one-cycle illegal pulse.
module mc_control (
    input  logic         clk,
    input  logic         reset,
    mc_control_if.master bus
);
    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        RCOMP  = 4'd7,
        BRANCH = 4'd8,
        JUMP   = 4'd9,
        ADDIEX = 4'd10,
        ADDIWB = 4'd11
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;

    typedef struct packed {
        logic       pcwrite;
        logic       pcwritecond;
        logic       iord;
        logic       memread;
        logic       memwrite;
        logic       irwrite;
        logic       memtoreg;
        logic       regdst;
        logic       regwrite;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic       aluop1;
        logic       aluop0;
        logic [1:0] pcsource;
    } ctl_t;

    state_t cur, nxt;
    logic   illegal_q, illegal_d;
    ctl_t   ctl, ctl_out;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur       <= FETCH;
            illegal_q <= 1'b0;
        end else begin
            cur       <= nxt;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        nxt       = cur;
        illegal_d = 1'b0;
        ctl       = '0;
        case (cur)
            FETCH: begin
                ctl.memread = 1'b1;
                ctl.alusrcb = 2'b01;
                ctl.irwrite = bus.mem_ready;
                ctl.pcwrite = bus.mem_ready;
                if (bus.mem_ready) nxt = DECODE;
            end
            DECODE: begin
                ctl.alusrcb = 2'b11;
                case (bus.op)
                    OP_R:         nxt = EXEC;
                    OP_LW, OP_SW: nxt = MEMADR;
                    OP_BEQ:       nxt = BRANCH;
                    OP_J:         nxt = JUMP;
                    OP_ADDI:      nxt = ADDIEX;
                    default: begin
                        nxt       = FETCH;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            MEMADR: begin
                ctl.alusrca = 1'b1;
                ctl.alusrcb = 2'b10;
                // op can only differ from lw/sw here if IR was corrupted; recover via FETCH
                if (bus.op == OP_LW)      nxt = MEMRD;
                else if (bus.op == OP_SW) nxt = MEMWR;
                else                      nxt = FETCH;
            end
            MEMRD: begin
                ctl.memread = 1'b1;
                ctl.iord    = 1'b1;
                if (bus.mem_ready) nxt = MEMWB;
            end
            MEMWB: begin
                ctl.regwrite = 1'b1;
                ctl.memtoreg = 1'b1;
                nxt          = FETCH;
            end
            MEMWR: begin
                ctl.memwrite = 1'b1;
                ctl.iord     = 1'b1;
                if (bus.mem_ready) nxt = FETCH;
            end
            EXEC: begin
                ctl.alusrca = 1'b1;
                ctl.aluop1  = 1'b1;
                nxt         = RCOMP;
            end
            RCOMP: begin
                ctl.regwrite = 1'b1;
                ctl.regdst   = 1'b1;
                nxt          = FETCH;
            end
            BRANCH: begin
                ctl.alusrca     = 1'b1;
                ctl.aluop0      = 1'b1;
                ctl.pcwritecond = 1'b1;
                ctl.pcsource    = 2'b01;
                nxt             = FETCH;
            end
            JUMP: begin
                ctl.pcwrite  = 1'b1;
                ctl.pcsource = 2'b10;
                nxt          = FETCH;
            end
            ADDIEX: begin
                ctl.alusrca = 1'b1;
                ctl.alusrcb = 2'b10;
                nxt         = ADDIWB;
            end
            ADDIWB: begin
                ctl.regwrite = 1'b1;
                nxt          = FETCH;
            end
            default: nxt = FETCH;
        endcase
    end

    // Reset masks everything combinationally so no strobe leaks before the first edge.
    assign ctl_out = reset ? '0 : ctl;

    assign bus.pcwrite     = ctl_out.pcwrite;
    assign bus.pcwritecond = ctl_out.pcwritecond;
    assign bus.iord        = ctl_out.iord;
    assign bus.memread     = ctl_out.memread;
    assign bus.memwrite    = ctl_out.memwrite;
    assign bus.irwrite     = ctl_out.irwrite;
    assign bus.memtoreg    = ctl_out.memtoreg;
    assign bus.regdst      = ctl_out.regdst;
    assign bus.regwrite    = ctl_out.regwrite;
    assign bus.alusrca     = ctl_out.alusrca;
    assign bus.alusrcb     = ctl_out.alusrcb;
    assign bus.aluop1      = ctl_out.aluop1;
    assign bus.aluop0      = ctl_out.aluop0;
    assign bus.pcsource    = ctl_out.pcsource;
    assign bus.illegal     = illegal_q;
    assign bus.state       = cur;
endmodule

// File: tb/tb_mc_control.sv
// Self-checking bench for mc_control: directed scenarios plus a randomized instruction stream
// compared cycle by cycle against a per-instruction cycle-plan model.
module tb_mc_control;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mc_control_if bus();
    mc_control dut (.clk(clk), .reset(reset), .bus(bus.master));

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;

    typedef struct {
        int         st;
        logic       rdy;
        logic [5:0] op;
        logic       ill;
    } plan_t;

    plan_t plan[$];

    // Packed order: pcwrite pcwritecond iord memread memwrite irwrite memtoreg regdst
    //               regwrite alusrca alusrcb[1:0] aluop1 aluop0 pcsource[1:0]
    function automatic logic [15:0] outs();
        return {bus.pcwrite, bus.pcwritecond, bus.iord, bus.memread, bus.memwrite,
                bus.irwrite, bus.memtoreg, bus.regdst, bus.regwrite, bus.alusrca,
                bus.alusrcb, bus.aluop1, bus.aluop0, bus.pcsource};
    endfunction

    function automatic logic [15:0] exp_vec(input int st, input logic rdy);
        logic pcw = 0, pcwc = 0, iord = 0, mrd = 0, mwr = 0, irw = 0, m2r = 0, rdst = 0;
        logic rw = 0, asa = 0, a1 = 0, a0 = 0;
        logic [1:0] asb = 2'b00, pcs = 2'b00;
        case (st)
            0:  begin mrd = 1; asb = 2'b01; irw = rdy; pcw = rdy; end
            1:  asb = 2'b11;
            2:  begin asa = 1; asb = 2'b10; end
            3:  begin mrd = 1; iord = 1; end
            4:  begin rw = 1; m2r = 1; end
            5:  begin mwr = 1; iord = 1; end
            6:  begin asa = 1; a1 = 1; end
            7:  begin rw = 1; rdst = 1; end
            8:  begin asa = 1; a0 = 1; pcwc = 1; pcs = 2'b01; end
            9:  begin pcw = 1; pcs = 2'b10; end
            10: begin asa = 1; asb = 2'b10; end
            11: rw = 1;
            default: ;
        endcase
        return {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa, asb, a1, a0, pcs};
    endfunction

    function automatic bit is_defined(input logic [5:0] o);
        return (o == OP_R) || (o == OP_LW) || (o == OP_SW) || (o == OP_BEQ) ||
               (o == OP_J) || (o == OP_ADDI);
    endfunction

    function automatic void push(input int st, input logic rdy, input logic [5:0] o, input logic ill);
        plan_t e;
        e.st = st; e.rdy = rdy; e.op = o; e.ill = ill;
        plan.push_back(e);
    endfunction

    // Drive inputs on the falling edge and let outputs settle before sampling.
    task automatic step(input logic rdy, input logic [5:0] o);
        @(negedge clk);
        bus.mem_ready = rdy;
        bus.op        = o;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.mem_ready = 1'b1;
        bus.op = OP_SW;
        #1;
        n_checks++;
        if (bus.state !== 4'd0 || outs() !== 16'h0 || bus.illegal !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_init: state=%0d outs=%h illegal=%b, want 0/0000/0", bus.state, outs(), bus.illegal);
        end
        @(negedge clk);
        reset = 1'b0;
        bus.mem_ready = 1'b0;
        #1;
        // sw into MEMWR and stall there
        step(1'b1, OP_SW); step(1'b1, OP_SW); step(1'b1, OP_SW); step(1'b0, OP_SW);
        n_checks++;
        if (bus.state !== 4'd5 || bus.memwrite !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_reach_memwr: state=%0d memwrite=%b, want 5/1", bus.state, bus.memwrite);
        end
        #2;
        bus.mem_ready = 1'b1;
        reset = 1'b1;
        #1;
        n_checks++;
        if (bus.memwrite !== 1'b0 || bus.state !== 4'd0 || outs() !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_mid_memwr: memwrite=%b state=%0d outs=%h, want 0/0/0000", bus.memwrite, bus.state, outs());
        end
        @(negedge clk);
        reset = 1'b0;
        bus.mem_ready = 1'b1;
        bus.op = OP_J;
        #1;
        n_checks++;
        if (bus.state !== 4'd0 || outs() !== 16'h9410) begin
            n_fail++;
            $display("FAIL reset_release_fetch: state=%0d outs=%h, want 0/9410", bus.state, outs());
        end
        step(1'b0, OP_J); step(1'b0, OP_J); step(1'b0, OP_J);
        n_checks++;
        if (bus.state !== 4'd0 || bus.pcwrite !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_recover_idle: state=%0d pcwrite=%b, want 0/0", bus.state, bus.pcwrite);
        end
    endtask

    task automatic test_lw();
        int exp_st[6] = '{0, 1, 2, 3, 4, 0};
        for (int i = 0; i < 6; i++) begin
            step(i < 5, OP_LW);
            n_checks++;
            if (bus.state !== 4'(exp_st[i])) begin
                n_fail++;
                $display("FAIL lw_state[%0d]: got %0d want %0d", i, bus.state, exp_st[i]);
            end
            if (exp_st[i] == 4) begin
                n_checks++;
                if ({bus.regwrite, bus.memtoreg, bus.regdst} !== 3'b110) begin
                    n_fail++;
                    $display("FAIL lw_memwb: got %b want 110", {bus.regwrite, bus.memtoreg, bus.regdst});
                end
            end
        end
    endtask

    task automatic test_rtype();
        int exp_st[5] = '{0, 1, 6, 7, 0};
        for (int i = 0; i < 5; i++) begin
            step(i < 4, OP_R);
            n_checks++;
            if (bus.state !== 4'(exp_st[i])) begin
                n_fail++;
                $display("FAIL rtype_state[%0d]: got %0d want %0d", i, bus.state, exp_st[i]);
            end
            if (exp_st[i] == 6) begin
                n_checks++;
                if ({bus.aluop1, bus.aluop0, bus.alusrca, bus.alusrcb} !== 5'b10100) begin
                    n_fail++;
                    $display("FAIL rtype_exec: got %b want 10100", {bus.aluop1, bus.aluop0, bus.alusrca, bus.alusrcb});
                end
            end
            if (exp_st[i] == 7) begin
                n_checks++;
                if ({bus.regwrite, bus.regdst} !== 2'b11) begin
                    n_fail++;
                    $display("FAIL rtype_rcomp: got %b want 11", {bus.regwrite, bus.regdst});
                end
            end
        end
    endtask

    task automatic test_beq_j();
        int exp_st[7] = '{0, 1, 8, 0, 1, 9, 0};
        logic [5:0] o;
        for (int i = 0; i < 7; i++) begin
            o = (i < 3) ? OP_BEQ : OP_J;
            step(i < 6, o);
            n_checks++;
            if (bus.state !== 4'(exp_st[i])) begin
                n_fail++;
                $display("FAIL beqj_state[%0d]: got %0d want %0d", i, bus.state, exp_st[i]);
            end
            if (exp_st[i] == 8) begin
                n_checks++;
                if ({bus.pcwritecond, bus.aluop0, bus.pcsource, bus.pcwrite} !== 5'b11010) begin
                    n_fail++;
                    $display("FAIL beq_branch: got %b want 11010", {bus.pcwritecond, bus.aluop0, bus.pcsource, bus.pcwrite});
                end
            end
            if (exp_st[i] == 9) begin
                n_checks++;
                if ({bus.pcwrite, bus.pcsource, bus.pcwritecond} !== 4'b1100) begin
                    n_fail++;
                    $display("FAIL j_jump: got %b want 1100", {bus.pcwrite, bus.pcsource, bus.pcwritecond});
                end
            end
        end
    endtask

    task automatic test_sw_stall();
        int   exp_st[8] = '{0, 1, 2, 5, 5, 5, 5, 0};
        logic rdy[8]    = '{1, 1, 1, 0, 0, 0, 1, 0};
        for (int i = 0; i < 8; i++) begin
            step(rdy[i], OP_SW);
            n_checks++;
            if (bus.state !== 4'(exp_st[i])) begin
                n_fail++;
                $display("FAIL sw_stall_state[%0d]: got %0d want %0d", i, bus.state, exp_st[i]);
            end
            if (exp_st[i] == 5) begin
                n_checks++;
                if ({bus.memwrite, bus.iord, bus.pcwrite, bus.irwrite} !== 4'b1100) begin
                    n_fail++;
                    $display("FAIL sw_stall_strobes[%0d]: got %b want 1100", i, {bus.memwrite, bus.iord, bus.pcwrite, bus.irwrite});
                end
            end
        end
    endtask

    task automatic test_illegal();
        int   exp_st[4]  = '{0, 1, 0, 0};
        logic exp_ill[4] = '{0, 0, 1, 0};
        logic rdy[4]     = '{1, 1, 0, 0};
        for (int i = 0; i < 4; i++) begin
            step(rdy[i], 6'b111111);
            n_checks++;
            if (bus.state !== 4'(exp_st[i]) || bus.illegal !== exp_ill[i] ||
                bus.regwrite !== 1'b0 || bus.memwrite !== 1'b0) begin
                n_fail++;
                $display("FAIL illegal[%0d]: state=%0d ill=%b rw=%b mw=%b, want %0d/%b/0/0",
                         i, bus.state, bus.illegal, bus.regwrite, bus.memwrite, exp_st[i], exp_ill[i]);
            end
        end
    endtask

    // Builds a per-cycle plan from each instruction's cycle sequence, then replays it.
    task automatic test_random();
        logic       pend_ill = 1'b0;
        logic [5:0] o;
        int         kind, w;
        plan.delete();
        for (int k = 0; k < 60; k++) begin
            kind = $urandom_range(0, 6);
            case (kind)
                0: o = OP_R;
                1: o = OP_LW;
                2: o = OP_SW;
                3: o = OP_BEQ;
                4: o = OP_J;
                5: o = OP_ADDI;
                default: begin
                    o = 6'($urandom);
                    while (is_defined(o)) o = 6'($urandom);
                end
            endcase
            w = $urandom_range(0, 2);
            for (int i = 0; i < w; i++) begin
                push(0, 1'b0, 6'($urandom), pend_ill);
                pend_ill = 1'b0;
            end
            push(0, 1'b1, 6'($urandom), pend_ill);
            pend_ill = 1'b0;
            push(1, 1'($urandom), o, 1'b0);
            case (kind)
                0: begin push(6, 1'($urandom), 6'($urandom), 0); push(7, 1'($urandom), 6'($urandom), 0); end
                1: begin
                    push(2, 1'($urandom), o, 0);
                    w = $urandom_range(0, 3);
                    for (int i = 0; i < w; i++) push(3, 1'b0, 6'($urandom), 0);
                    push(3, 1'b1, 6'($urandom), 0);
                    push(4, 1'($urandom), 6'($urandom), 0);
                end
                2: begin
                    push(2, 1'($urandom), o, 0);
                    w = $urandom_range(0, 3);
                    for (int i = 0; i < w; i++) push(5, 1'b0, 6'($urandom), 0);
                    push(5, 1'b1, 6'($urandom), 0);
                end
                3: push(8, 1'($urandom), 6'($urandom), 0);
                4: push(9, 1'($urandom), 6'($urandom), 0);
                5: begin push(10, 1'($urandom), 6'($urandom), 0); push(11, 1'($urandom), 6'($urandom), 0); end
                default: pend_ill = 1'b1;
            endcase
        end
        push(0, 1'b0, 6'($urandom), pend_ill);
        for (int i = 0; i < plan.size(); i++) begin
            step(plan[i].rdy, plan[i].op);
            n_checks++;
            if (bus.state !== 4'(plan[i].st) || outs() !== exp_vec(plan[i].st, plan[i].rdy) ||
                bus.illegal !== plan[i].ill) begin
                n_fail++;
                $display("FAIL random[%0d]: state=%0d outs=%h ill=%b, want %0d/%h/%b", i, bus.state,
                         outs(), bus.illegal, plan[i].st, exp_vec(plan[i].st, plan[i].rdy), plan[i].ill);
            end
        end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_rtype();
        test_beq_j();
        test_sw_stall();
        test_illegal();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mc_control.md
# mc_control

Main control state machine for the multicycle MIPS datapath. It sequences each instruction through fetch, decode, execute, memory and writeback. It drives every datapath enable and mux select, and supplies `aluop1`/`aluop0` to the ALU control decoder. It stalls on a memory ready handshake and flags undefined opcodes.

## Interface
- No parameters.
- `clk` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-high reset. Clock is `clk`.
- `op` in 6: opcode field, IR[31:26], taken from the instruction register.
- `mem_ready` in 1: memory has completed the current read or write this cycle.
- `pcwrite` out 1: unconditional PC load.
- `pcwritecond` out 1: PC load if the ALU zero flag is set (branch).
- `iord` out 1: memory address select. 0 = PC, 1 = ALUOut.
- `memread` out 1: memory read request.
- `memwrite` out 1: memory write request.
- `irwrite` out 1: instruction register load.
- `memtoreg` out 1: register write data select. 0 = ALUOut, 1 = MDR.
- `regdst` out 1: destination register select. 0 = rt, 1 = rd.
- `regwrite` out 1: register file write.
- `alusrca` out 1: ALU A select. 0 = PC, 1 = A.
- `alusrcb` out 2: ALU B select. 00 = B, 01 = 4, 10 = sign-extended immediate, 11 = shifted sign-extended immediate.
- `aluop1`, `aluop0` out 1 each: to ALU control. 00 = add, 01 = subtract, 10 = decode funct.
- `pcsource` out 2: PC source. 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `illegal` out 1: registered one-cycle pulse on an undefined opcode.
- `state` out 4: current state, for debug.

## Operation
- State encoding:
  - 0 FETCH
  - 1 DECODE
  - 2 MEMADR
  - 3 MEMRD
  - 4 MEMWB
  - 5 MEMWR
  - 6 EXEC
  - 7 RCOMP
  - 8 BRANCH
  - 9 JUMP
  - 10 ADDIEX
  - 11 ADDIWB
  - Codes 12–15 are unused and go to FETCH on the next edge.
- Outputs are Moore, decoded from `state`. The only exception is that `mem_ready` gates the strobes noted below.
- Any output not listed for a state is 0.
- Per-state outputs:
  - FETCH: `memread`=1, `alusrcb`=01.
    - `irwrite` = `pcwrite` = `mem_ready`.
    - Stay in FETCH while `mem_ready`=0. Go to DECODE when it is 1.
  - DECODE: `alusrcb`=11. Next state depends on `op`:
    - 000000 (R-type) → EXEC.
    - 100011 (lw) or 101011 (sw) → MEMADR.
    - 000100 (beq) → BRANCH.
    - 000010 (j) → JUMP.
    - 001000 (addi) → ADDIEX.
    - Any other opcode → FETCH, with `illegal`=1 in the following cycle.
  - MEMADR: `alusrca`=1, `alusrcb`=10. Go to MEMRD if lw, MEMWR if sw.
  - MEMRD: `memread`=1, `iord`=1. Hold until `mem_ready`, then go to MEMWB.
  - MEMWB: `regwrite`=1, `memtoreg`=1, `regdst`=0. Go to FETCH.
  - MEMWR: `memwrite`=1, `iord`=1. Hold until `mem_ready`, then go to FETCH.
  - EXEC: `alusrca`=1, `alusrcb`=00, `aluop1`=1. Go to RCOMP.
  - RCOMP: `regwrite`=1, `regdst`=1. Go to FETCH.
  - BRANCH: `alusrca`=1, `aluop0`=1, `pcwritecond`=1, `pcsource`=01. Go to FETCH.
  - JUMP: `pcwrite`=1, `pcsource`=10. Go to FETCH.
  - ADDIEX: `alusrca`=1, `alusrcb`=10. Go to ADDIWB.
  - ADDIWB: `regwrite`=1, `regdst`=0. Go to FETCH.
- `op` is sampled only in DECODE and MEMADR. It is ignored in all other states.

## Timing
- Reset:
  - Asserting `reset` forces `state`=FETCH and `illegal`=0 immediately, without waiting for a clock edge.
  - While `reset`=1, all outputs are 0 regardless of `mem_ready`: every write strobe (`pcwrite`, `pcwritecond`, `irwrite`, `regwrite`, `memwrite`), `memread`, and every mux select.
  - The first FETCH cycle is the first cycle after `reset` deasserts.
- Reset in the middle of an instruction abandons it. No strobe from the old state may appear after reset asserts.
- Cycles per instruction with zero wait states (`mem_ready` held at 1):
  - lw: 5
  - sw: 4
  - R-type: 4
  - addi: 4
  - beq: 3
  - j: 3
  - Undefined opcode: 2
- Each cycle with `mem_ready`=0 in FETCH, MEMRD or MEMWR adds exactly one cycle.
- While stalled:
  - `memread`/`memwrite` and `iord` stay stable.
  - `pcwrite` and `irwrite` stay 0.
- `illegal` is high for exactly one cycle: the FETCH cycle that follows the DECODE cycle with the undefined opcode.
- If `mem_ready` changes after the clock edge, only the gated FETCH strobes follow it within that cycle. State advances only on the clock edge.

## Test plan
- Reset asserted mid-MEMWR, then released:
  - `memwrite` drops to 0 immediately and `state`=0.
  - After release, with `mem_ready`=1: `memread`=1, `irwrite`=1, `pcwrite`=1, `alusrcb`=01.
- lw (op=100011) with `mem_ready`=1:
  - State sequence 0,1,2,3,4,0.
  - MEMWB cycle: `regwrite`=1, `memtoreg`=1, `regdst`=0.
- R-type (op=000000):
  - EXEC cycle: `aluop1`=1, `aluop0`=0, `alusrca`=1, `alusrcb`=00.
  - RCOMP cycle: `regwrite`=1, `regdst`=1.
  - Instruction completes in 4 cycles.
- beq then j:
  - BRANCH cycle: `pcwritecond`=1, `aluop0`=1, `pcsource`=01.
  - JUMP cycle: `pcwrite`=1, `pcsource`=10.
  - Each instruction takes 3 cycles.
- sw with `mem_ready`=0 for 3 cycles in MEMWR:
  - State stays 5 for 4 cycles with `memwrite`=1 and `iord`=1.
  - 7 cycles total.
- op=111111:
  - Goes DECODE → FETCH.
  - `illegal`=1 for one cycle only.
  - No `regwrite`/`memwrite` strobe at any point.
